// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and default timing constants for button debouncers
package debounce_pkg;
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;
    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pb_debouncer_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-low reset to 0
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    // shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/pb_debouncer.sv
// pb_debouncer: synchronise and debounce a push button; define PB_INVERT_EN for active-low buttons
module pb_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_db,
    output logic pb_busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic pb_in;
    logic s2;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
`ifdef PB_INVERT_EN
    assign pb_in = ~pb_raw;
`else
    assign pb_in = pb_raw;
`endif
    sync2 u_sync (
        .clk(clk),
        .rst(rst),
        .d(pb_in),
        .q(s2)
    );
    // state and stability counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // qualify a level change: count while the new level holds, abort on any opposite sample
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            LOW:       state_nx = s2 ? WAIT_HIGH : LOW;
            WAIT_HIGH: begin
                if (!s2) state_nx = LOW;
                else if (cnt == LAST) state_nx = HIGH;
                else cnt_nx = cnt + 1'b1;
            end
            HIGH:      state_nx = s2 ? HIGH : WAIT_LOW;
            WAIT_LOW:  begin
                if (s2) state_nx = HIGH;
                else if (cnt == LAST) state_nx = LOW;
                else cnt_nx = cnt + 1'b1;
            end
            default:   state_nx = LOW;
        endcase
    end
    // outputs decode the registered state only, so an aborted wait never moves pb_db
    always_comb begin
        pb_db   = (state == HIGH) || (state == WAIT_LOW);
        pb_busy = (state == WAIT_HIGH) || (state == WAIT_LOW);
    end
endmodule

// File: tb/tb_pb_debouncer.sv
// tb_pb_debouncer: directed checks of pb_debouncer with STABLE_CYCLES=4, CNT_W=3
module tb_pb_debouncer;
`ifdef PB_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb_raw = INV;
    logic pb_db;
    logic pb_busy;
    int total = 0;
    int bad = 0;

    pb_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .pb_raw(pb_raw),
        .pb_db(pb_db),
        .pb_busy(pb_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic lvl);
        pb_raw = lvl ^ INV;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_change(input string tag, input logic lvl);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk({tag, "_busy"}, pb_busy, (i >= 3 && i <= 6));
            chk({tag, "_db"}, pb_db, (i == 7) ? lvl : ~lvl);
        end
    endtask

    task automatic settle(input string tag, input logic lvl, input int n);
        press(lvl);
        for (int i = 0; i < n; i++) tick();
        chk({tag, "_db"}, pb_db, lvl);
        chk({tag, "_busy"}, pb_busy, 1'b0);
    endtask

    initial begin
        #1;
        rst = 1'b0;
        press(1'b1);
        #1;
        chk("rst_async_db", pb_db, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_db", pb_db, 1'b0);
            chk("rst_busy", pb_busy, 1'b0);
        end
        rst = 1'b1;
        expect_change("rst_rel", 1'b1);
        settle("pre_press", 1'b0, 10);
        press(1'b1);
        expect_change("press", 1'b1);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("press_hold_db", pb_db, 1'b1);
            chk("press_hold_busy", pb_busy, 1'b0);
        end
        settle("pre_bounce", 1'b0, 10);
        for (int r = 0; r < 4; r++) begin
            press(1'b1);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("bounce_hi_db", pb_db, 1'b0);
            end
            press(1'b0);
            for (int i = 0; i < 2; i++) begin
                tick();
                chk("bounce_lo_db", pb_db, 1'b0);
            end
        end
        press(1'b1);
        expect_change("bounce_end", 1'b1);
        settle("pre_release", 1'b1, 6);
        press(1'b0);
        tick();
        chk("rel_l1_db", pb_db, 1'b1);
        chk("rel_l1_busy", pb_busy, 1'b0);
        tick();
        chk("rel_l2_db", pb_db, 1'b1);
        press(1'b1);
        tick();
        chk("glitch1_db", pb_db, 1'b1);
        chk("glitch1_busy", pb_busy, 1'b1);
        tick();
        chk("glitch2_db", pb_db, 1'b1);
        chk("glitch2_busy", pb_busy, 1'b1);
        press(1'b0);
        expect_change("release", 1'b0);
        settle("pre_midrst", 1'b0, 5);
        press(1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_wait_busy", pb_busy, 1'b1);
        chk("midrst_wait_db", pb_db, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_async_busy", pb_busy, 1'b0);
        chk("midrst_async_db", pb_db, 1'b0);
        tick();
        tick();
        chk("midrst_hold_busy", pb_busy, 1'b0);
        rst = 1'b1;
        expect_change("midrst_rel", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pb_debouncer.md
# pb_debouncer

Synchronises and debounces a raw mechanical push-button input and produces a clean, glitch-free level. It sits directly upstream of the single-pulse generator: `pb_db` drives that stage's button input, which converts each debounced press into a one-cycle enable. The block has two parts:
- a two-flop synchroniser;
- a four-state FSM with a stability counter that accepts a level change only after it has held for a programmable number of cycles.

## Interface
Parameters:
- `STABLE_CYCLES`, default 50000: the number of consecutive cycles a new level must hold after first detection (1 ms at 50 MHz). Must be ≥ 1.
- `CNT_W`, default 16: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES - 1.

Ports:
- `clk`, input, 1 bit: the single system clock. All logic is on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on `clk`.
- `pb_raw`, input, 1 bit: raw button, asynchronous to `clk`. It is bouncy and active-high, unless `PB_INVERT_EN` is defined.
- `pb_db`, output, 1 bit: debounced level. It is derived from registered state only.
- `pb_busy`, output, 1 bit: high while a level change is being qualified (either WAIT state).

## Operation
- Input path: `pb_raw`, optionally inverted, feeds sync flops `s1` → `s2`. The FSM uses only `s2`.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. The counter `cnt` is `CNT_W` bits wide.
- **LOW:** if `s2` = 1, go to WAIT_HIGH and set `cnt` ← 0. Otherwise stay.
- **WAIT_HIGH:**
  - if `s2` = 0, go to LOW and set `cnt` ← 0;
  - else if `cnt` = STABLE_CYCLES-1, go to HIGH;
  - else `cnt` ← `cnt`+1.
- **HIGH:** if `s2` = 0, go to WAIT_LOW and set `cnt` ← 0. Otherwise stay.
- **WAIT_LOW:**
  - if `s2` = 1, go to HIGH and set `cnt` ← 0;
  - else if `cnt` = STABLE_CYCLES-1, go to LOW;
  - else `cnt` ← `cnt`+1.
- Illegal state encodings return to LOW.
- Outputs:
  - `pb_db` = 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH. An aborted qualification therefore never toggles `pb_db`.
  - `pb_busy` = 1 in WAIT_HIGH and WAIT_LOW.
- Acceptance rule: a change is accepted only after STABLE_CYCLES+1 consecutive samples of the new value on `s2`. Any opposite sample restarts qualification from the stable state.
- Counter: never exceeds STABLE_CYCLES-1 and never wraps. In stable states its value is don't-care but is held at 0.
- Reset values: state LOW, `cnt` = 0, `s1` = `s2` = 0, `pb_db` = 0, `pb_busy` = 0.

## Timing
- Latency: let edge E be the first rising edge that samples the new `pb_raw` level. `pb_db` changes after edge E+STABLE_CYCLES+2, i.e. on the (STABLE_CYCLES+3)th edge counting E as the first.
- `pb_busy` timing:
  - rises after edge E+2;
  - falls together with the `pb_db` change;
  - falls one edge after the first opposite sample on `s2` (abort).
- `pb_db` never changes more than once per STABLE_CYCLES+1 cycles.
- Reset asserted mid-qualification: outputs go to 0 asynchronously. After release, qualification restarts from LOW with the full latency.
- `pb_raw` held high through reset release: rises on `pb_db` after the full latency. No pulse is suppressed or invented.
- STABLE_CYCLES = 1: a change needs 2 consecutive `s2` samples.

## Configuration
- Macro `PB_INVERT_EN`:
  - when defined, `pb_raw` is inverted before `s1`, for active-low board buttons. A released button (`pb_raw` = 1) then reads as 0, consistent with reset.
  - when undefined, `pb_raw` is used as-is.
- `pb_db` is active-high in both builds.

## Structure
- Shared package `debounce_pkg` holds:
  - the state enum typedef (LOW, WAIT_HIGH, HIGH, WAIT_LOW, 2-bit encoding);
  - the default STABLE_CYCLES and CNT_W constants.
- One sub-module, `sync2`: a 2-flop synchroniser with asynchronous active-low reset to 0. It is reused by other button inputs.

## Test plan
All scenarios use STABLE_CYCLES = 4 and CNT_W = 3.
1. Reset: `rst` = 0 with `pb_raw` = 1 for 10 cycles → `pb_db` = 0 and `pb_busy` = 0 throughout. After release, `pb_db` rises on the 7th edge.
2. Clean press: `pb_raw` 0→1, held 20 cycles → `pb_busy` high after the 3rd through 6th edges, `pb_db` = 1 after the 7th edge, no further toggles.
3. Bounce: `pb_raw` toggles 3 cycles high / 2 cycles low ×4, then held high → `pb_db` stays 0 during the bounce and rises 7 edges after the final rising sample.
4. Release: from a stable HIGH, `pb_raw` 1→0 with a 2-cycle high glitch after 2 cycles → `pb_db` stays 1 through the glitch and falls 7 edges after the glitch ends.
5. Mid-wait reset: `rst` pulsed low while in WAIT_HIGH → `pb_db` = `pb_busy` = 0 immediately. With `pb_raw` still high, `pb_db` rises on the 7th edge after release.
6. `PB_INVERT_EN` defined: `pb_raw` held 1 → `pb_db` = 0. `pb_raw` 1→0 → `pb_db` = 1 after 7 edges.
